ir_frame_decoder: RTL and testbench
===================================

# ir_frame_decoder

Parametrised pulse-distance IR frame decoder for NEC-style remotes, the successor to the fixed 32-bit decoder. It takes the raw active-low demodulator output and synchronises and deglitches it internally. It measures every pulse with its own edge-to-edge counter and assembles a frame of `NBITS` bits in either bit order. It also recognises NEC repeat frames, optionally checks address/command inverse bytes, and reports per-stage error codes. The block sits between the IR receiver pin and the game-input logic.

## Interface
- `NBITS`, 32: data bits per frame, 1..64.
- `SBD`, 900_000: sync burst, in cycles.
- `SSD`, 450_000: sync space for a data frame, in cycles.
- `RSD`, 225_000: sync space for a repeat frame, in cycles.
- `BBD`, 56_000: bit burst, in cycles.
- `BSD0`, 56_000: bit space for a 0, in cycles.
- `BSD1`, 169_000: bit space for a 1, in cycles.
- `MARGIN`, 20_000: allowed ± tolerance on every duration, window inclusive.
- `FILT`, 16: deglitch length; a level is accepted after it has been stable for `FILT` consecutive cycles.
- `LSB_FIRST`, 1: 1 means bit k lands in `code_out[k]`; 0 means MSB-first shift.
- `CHECK_INV`, 1: inverse-byte check; valid only when `NBITS` = 32, ignored otherwise.
- `clk_in` in 1: 100 MHz clock.
- `rst_n_in` in 1: reset, **asynchronous, active-low**.
- `signal_in` in 1: raw IR input, asynchronous; low means a burst is present.
- `code_out` out `NBITS`: last valid code; held until the next valid frame.
- `new_code_out` out 1: one-cycle pulse when `code_out` updates.
- `repeat_out` out 1: one-cycle pulse when a valid repeat frame is received.
- `error_out` out 3: last error code; cleared at the start of each sync burst.
- `state_out` out 4: current FSM state encoding.

## Operation
- Input path:
  - 2-FF synchroniser, then the deglitch filter, producing `filt`; `filt` resets to 1.
  - An edge is a change of `filt`.
  - `dur` is a 32-bit cycle counter of the current `filt` level. It saturates at all-ones and resets to 1 on each edge.
  - On each edge the decoder compares the `dur` of the level that just ended against the window [X−MARGIN, X+MARGIN].
- FSM states: IDLE=0, SYNC_B=1, SYNC_S=2, BIT_B=3, BIT_S=4, REP_B=5, DONE=6.
  - IDLE: a falling edge goes to SYNC_B and clears `error_out`.
  - SYNC_B: a rising edge with `dur` in the SBD window goes to SYNC_S. Otherwise error 1.
  - SYNC_S: a falling edge is classified by `dur`:
    - in the SSD window: clear the shift register and bit count, then go to BIT_B;
    - in the RSD window: go to REP_B;
    - otherwise: error 2.
  - BIT_B: a rising edge with `dur` in the BBD window goes to BIT_S. Otherwise error 3.
  - BIT_S: a falling edge is classified by `dur`:
    - in the BSD0 window: shift in a 0;
    - in the BSD1 window: shift in a 1;
    - otherwise: error 4.
    - After the shift, if the bit count is `NBITS`, go to DONE; else go to BIT_B.
  - DONE: if `CHECK_INV`=1 and `NBITS`=32 and either `[15:8]` ≠ ~`[7:0]` or `[31:24]` ≠ ~`[23:16]`, set error 5. Otherwise load `code_out` and pulse `new_code_out`. Either way return to IDLE.
  - REP_B: a rising edge with `dur` in the BBD window is handled as follows:
    - if a valid code has been received since reset: pulse `repeat_out`, leave `code_out` unchanged;
    - else: error 6.
    - Bad width: error 3. Either way return to IDLE.
- Timeout: in any non-IDLE state, if `dur` exceeds (largest window upper bound for that state) with no edge, set the state's error code and go to IDLE. IDLE itself never times out.
- Any error leaves `code_out` unchanged and emits no pulse.
- `NBITS` = 64 uses a 7-bit bit counter. The bit count never wraps because it is compared before each shift.
- Windows that overlap (e.g. BSD0 and BSD1 with a large MARGIN): BSD0 wins.

## Timing
- Reset values: `code_out` = 0, `new_code_out` = 0, `repeat_out` = 0, `error_out` = 0, `state_out` = 0, `filt` = 1, `dur` = 0, repeat-enable flag = 0.
- Asserting `rst_n_in` mid-frame aborts immediately. No pulse is emitted, and the first falling edge after release starts a fresh frame.
- A raw edge reaches `filt` 2+`FILT` cycles later.
- `new_code_out` rises 2 cycles after the `filt` edge that ends bit `NBITS`−1 (that edge → DONE → pulse). `code_out` is valid in the same cycle and stays valid afterwards.
- `repeat_out` rises 1 cycle after the qualifying rising `filt` edge.
- Pulses are exactly 1 cycle wide. `new_code_out` and `repeat_out` are never high together.
- The error code is registered on the cycle the FSM returns to IDLE and holds until the next falling edge in IDLE.

## Test plan
All scenarios use bench parameters SBD=900, SSD=450, RSD=225, BBD=56, BSD0=56, BSD1=169, MARGIN=20, FILT=4.
- **Valid NEC frame.** Addr 0x04, cmd 0x08, LSB-first, so the code is 0xF708FB04 → `code_out`=0xF708FB04, one `new_code_out` pulse 2 cycles after the filtered final edge, `error_out`=0.
- **Repeat after valid frame.** The 900/225/56 pattern sent after the previous scenario → one `repeat_out` pulse, `code_out` still 0xF708FB04. The same pattern straight after reset → `error_out`=6, no pulse.
- **Inverse check.** A frame with byte1=0x00 and addr 0x04 → `error_out`=5, `code_out` unchanged. With `CHECK_INV`=0 the same frame → `new_code_out` pulse.
- **Bad timings.**
  - Sync burst of 700 cycles → error 1.
  - Bit space of 110 cycles → error 4.
  - Input held high for 400 cycles inside BIT_S → error 4 via timeout.
  - A subsequent valid frame decodes correctly.
- **Glitch and reset.**
  - 2-cycle spikes during bursts and spaces → frame decodes unaffected.
  - `rst_n_in` pulsed low mid-bit-16 → outputs return to reset values asynchronously, no pulse, next frame decodes.
- **Parametrised variant.** `NBITS`=12, `LSB_FIRST`=0 with bits 1010_0011_1100 → `code_out`=0xA3C, one `new_code_out` pulse.

Source files
------------

// File: rtl/ir_frame_decoder.sv
// NEC-style pulse-distance IR decoder: sync + deglitch, windowed pulse widths, NBITS-bit frames, repeat and inverse checks.
// Latency: raw edge -> filt in 2+FILT cycles, new_code_out 2 cycles later; no backpressure, outputs are single-cycle pulses.
module ir_frame_decoder #(
  parameter int NBITS     = 32,
  parameter int SBD       = 900_000,
  parameter int SSD       = 450_000,
  parameter int RSD       = 225_000,
  parameter int BBD       = 56_000,
  parameter int BSD0      = 56_000,
  parameter int BSD1      = 169_000,
  parameter int MARGIN    = 20_000,
  parameter int FILT      = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit CHECK_INV = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             signal_in,
  output logic [NBITS-1:0] code_out,
  output logic             new_code_out,
  output logic             repeat_out,
  output logic [2:0]       error_out,
  output logic [3:0]       state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC_B = 3'd1,
    SYNC_S = 3'd2,
    BIT_B  = 3'd3,
    BIT_S  = 3'd4,
    REP_B  = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic logic [31:0] win_lo(input int x);
    return (x > MARGIN) ? 32'(x - MARGIN) : 32'd0;
  endfunction

  function automatic logic [31:0] win_hi(input int x);
    return 32'(x + MARGIN);
  endfunction

  function automatic logic in_win(input logic [31:0] d, input int x);
    return (d >= win_lo(x)) && (d <= win_hi(x));
  endfunction

  localparam int FW = $clog2(FILT + 1);
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(NBITS - 1);
  localparam bit INV_EN = CHECK_INV && (NBITS == 32);

  // Per-state timeout: the largest window upper bound reachable from that state
  localparam logic [31:0] TO_SB = win_hi(SBD);
  localparam logic [31:0] TO_SS = (SSD > RSD) ? win_hi(SSD) : win_hi(RSD);
  localparam logic [31:0] TO_BB = win_hi(BBD);
  localparam logic [31:0] TO_BS = (BSD0 > BSD1) ? win_hi(BSD0) : win_hi(BSD1);

  logic          sync1, sync2, filt, filt_d;
  logic [FW-1:0] fcnt;
  logic [31:0]   dur;
  logic          lvl_chg, rise, fall;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
      dur    <= '0;
    end else begin
      sync1  <= signal_in;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FILT_LAST) begin
        filt <= sync2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
      if (lvl_chg)
        dur <= 32'd1;
      else if (dur != '1)
        dur <= dur + 32'd1;
    end
  end

  // dur still holds the length of the level that just ended on the cycle lvl_chg is seen
  assign lvl_chg = filt ^ filt_d;
  assign rise    = lvl_chg & filt;
  assign fall    = lvl_chg & ~filt;

  state_t           state;
  logic [NBITS-1:0] sr, sr_shift;
  logic [CW-1:0]    cnt;
  logic             rep_en;
  logic             bsd0, bsd1;
  logic [31:0]      sr32;
  logic             inv_bad;

  assign bsd0 = in_win(dur, BSD0);
  assign bsd1 = in_win(dur, BSD1);
  assign sr32 = 32'(sr);
  assign inv_bad = (sr32[15:8] != ~sr32[7:0]) || (sr32[31:24] != ~sr32[23:16]);

  // Overlapping windows resolve to 0 because bsd0 is tested first
  always_comb begin
    sr_shift = sr;
    if (LSB_FIRST)
      sr_shift = (sr >> 1) | (NBITS'(!bsd0) << (NBITS - 1));
    else
      sr_shift = (sr << 1) | NBITS'(!bsd0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      rep_en       <= 1'b0;
      code_out     <= '0;
      new_code_out <= 1'b0;
      repeat_out   <= 1'b0;
      error_out    <= '0;
    end else begin
      new_code_out <= 1'b0;
      repeat_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            error_out <= '0;
            state     <= SYNC_B;
          end
        end
        SYNC_B: begin
          if (rise) begin
            if (in_win(dur, SBD)) begin
              state <= SYNC_S;
            end else begin
              error_out <= 3'd1;
              state     <= IDLE;
            end
          end else if (dur > TO_SB) begin
            error_out <= 3'd1;
            state     <= IDLE;
          end
        end
        SYNC_S: begin
          if (fall) begin
            if (in_win(dur, SSD)) begin
              sr    <= '0;
              cnt   <= '0;
              state <= BIT_B;
            end else if (in_win(dur, RSD)) begin
              state <= REP_B;
            end else begin
              error_out <= 3'd2;
              state     <= IDLE;
            end
          end else if (dur > TO_SS) begin
            error_out <= 3'd2;
            state     <= IDLE;
          end
        end
        BIT_B: begin
          if (rise) begin
            if (in_win(dur, BBD)) begin
              state <= BIT_S;
            end else begin
              error_out <= 3'd3;
              state     <= IDLE;
            end
          end else if (dur > TO_BB) begin
            error_out <= 3'd3;
            state     <= IDLE;
          end
        end
        BIT_S: begin
          if (fall) begin
            if (bsd0 || bsd1) begin
              sr    <= sr_shift;
              cnt   <= cnt + CW'(1);
              state <= (cnt == BIT_LAST) ? DONE : BIT_B;
            end else begin
              error_out <= 3'd4;
              state     <= IDLE;
            end
          end else if (dur > TO_BS) begin
            error_out <= 3'd4;
            state     <= IDLE;
          end
        end
        REP_B: begin
          if (rise) begin
            if (!in_win(dur, BBD))
              error_out <= 3'd3;
            else if (rep_en)
              repeat_out <= 1'b1;
            else
              error_out <= 3'd6;
            state <= IDLE;
          end else if (dur > TO_BB) begin
            error_out <= 3'd3;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (INV_EN && inv_bad) begin
            error_out <= 3'd5;
          end else begin
            code_out     <= sr;
            new_code_out <= 1'b1;
            rep_en       <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_out = {1'b0, state};

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Directed bench for ir_frame_decoder: three instances (NEC/check-inverse, NEC/no-check, 12-bit MSB-first).
module tb_ir_frame_decoder;
  localparam int SBD = 900, SSD = 450, RSD = 225, BBD = 56, BSD0 = 56, BSD1 = 169, MARGIN = 20, FILT = 4;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic sig_a = 1'b1, sig_b = 1'b1, sig_c = 1'b1;
  logic [2:0] tgt = 3'b001;

  logic [31:0] code_a, code_b;
  logic [11:0] code_c;
  logic nc_a, nc_b, nc_c, rp_a, rp_b, rp_c;
  logic [2:0] err_a, err_b, err_c;
  logic [3:0] st_a, st_b, st_c;

  ir_frame_decoder #(.NBITS(32), .SBD(SBD), .SSD(SSD), .RSD(RSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .MARGIN(MARGIN), .FILT(FILT), .LSB_FIRST(1'b1), .CHECK_INV(1'b1)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .signal_in(sig_a), .code_out(code_a),
    .new_code_out(nc_a), .repeat_out(rp_a), .error_out(err_a), .state_out(st_a));

  ir_frame_decoder #(.NBITS(32), .SBD(SBD), .SSD(SSD), .RSD(RSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .MARGIN(MARGIN), .FILT(FILT), .LSB_FIRST(1'b1), .CHECK_INV(1'b0)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .signal_in(sig_b), .code_out(code_b),
    .new_code_out(nc_b), .repeat_out(rp_b), .error_out(err_b), .state_out(st_b));

  ir_frame_decoder #(.NBITS(12), .SBD(SBD), .SSD(SSD), .RSD(RSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .MARGIN(MARGIN), .FILT(FILT), .LSB_FIRST(1'b0), .CHECK_INV(1'b1)) dut_c (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .signal_in(sig_c), .code_out(code_c),
    .new_code_out(nc_c), .repeat_out(rp_c), .error_out(err_c), .state_out(st_c));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  int nca_n = 0, rpa_n = 0, ncb_n = 0, ncc_n = 0, both_n = 0;
  int nca_cyc = 0, rpa_cyc = 0, ncc_cyc = 0;
  int checks = 0, errors = 0;
  int t_mark = 0;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (nc_a) begin nca_n++; nca_cyc = cyc; end
    if (rp_a) begin rpa_n++; rpa_cyc = cyc; end
    if (nc_b) ncb_n++;
    if (nc_c) begin ncc_n++; ncc_cyc = cyc; end
    if (nc_a && rp_a) both_n++;
  end

  task automatic hold(input logic lvl, input int n);
    sig_a = tgt[0] ? lvl : 1'b1;
    sig_b = tgt[1] ? lvl : 1'b1;
    sig_c = tgt[2] ? lvl : 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_sync(input int space);
    hold(1'b0, SBD);
    hold(1'b1, space);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      hold(1'b0, 20); hold(1'b1, 2); hold(1'b0, 34);
      hold(1'b1, 30); hold(1'b0, 2); hold(1'b1, (b ? BSD1 : BSD0) - 32);
    end else begin
      hold(1'b0, BBD);
      hold(1'b1, b ? BSD1 : BSD0);
    end
  endtask

  // Bit i of v is the i-th bit on air unless msb is set
  task automatic send_frame(input logic [63:0] v, input int n, input logic msb, input logic glitch);
    if (glitch) begin
      hold(1'b0, 400); hold(1'b1, 2); hold(1'b0, 498); hold(1'b1, SSD);
    end else begin
      send_sync(SSD);
    end
    for (int i = 0; i < n; i++) send_bit(msb ? v[n-1-i] : v[i], glitch);
    t_mark = cyc;
    hold(1'b0, BBD);
    hold(1'b1, 30);
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    repeat (5) @(negedge clk_in);
    if ({code_a, code_b, 20'd0, code_c} !== 76'd0) begin
      $display("FAIL reset_code: got %h/%h/%h, expected 0", code_a, code_b, code_c); errors++; end
    checks++;
    if ({nc_a, nc_b, nc_c, rp_a, rp_b, rp_c} !== 6'd0) begin
      $display("FAIL reset_pulses: got %b, expected 000000", {nc_a, nc_b, nc_c, rp_a, rp_b, rp_c}); errors++; end
    checks++;
    if ({err_a, err_b, err_c, st_a, st_b, st_c} !== 21'd0) begin
      $display("FAIL reset_err_state: got %h, expected 0", {err_a, err_b, err_c, st_a, st_b, st_c}); errors++; end
    checks++;
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_valid_frame;
    int n0;
    tgt = 3'b001; n0 = nca_n;
    send_frame(64'hF708FB04, 32, 1'b0, 1'b0);
    if (code_a !== 32'hF708FB04) begin
      $display("FAIL valid_code: got %h, expected f708fb04", code_a); errors++; end
    checks++;
    if (nca_n - n0 !== 1) begin
      $display("FAIL valid_pulse: got %0d pulse cycles, expected 1", nca_n - n0); errors++; end
    checks++;
    if (nca_cyc - t_mark !== 8) begin
      $display("FAIL valid_latency: got %0d, expected 8", nca_cyc - t_mark); errors++; end
    checks++;
    if (err_a !== 3'd0) begin
      $display("FAIL valid_err: got %0d, expected 0", err_a); errors++; end
    checks++;
  endtask

  task automatic test_repeat;
    int n0, r0;
    tgt = 3'b001; n0 = nca_n; r0 = rpa_n;
    send_sync(RSD);
    hold(1'b0, BBD);
    t_mark = cyc;
    hold(1'b1, 30);
    if (rpa_n - r0 !== 1) begin
      $display("FAIL repeat_pulse: got %0d, expected 1", rpa_n - r0); errors++; end
    checks++;
    if (rpa_cyc - t_mark !== 7) begin
      $display("FAIL repeat_latency: got %0d, expected 7", rpa_cyc - t_mark); errors++; end
    checks++;
    if (code_a !== 32'hF708FB04 || nca_n !== n0) begin
      $display("FAIL repeat_code: got %h with %0d new pulses, expected f708fb04 and 0", code_a, nca_n - n0); errors++; end
    checks++;
  endtask

  task automatic test_inverse;
    int n0, b0;
    tgt = 3'b011; n0 = nca_n; b0 = ncb_n;
    send_frame(64'hF7080004, 32, 1'b0, 1'b0);
    if (err_a !== 3'd5) begin
      $display("FAIL inv_err: got %0d, expected 5", err_a); errors++; end
    checks++;
    if (code_a !== 32'hF708FB04 || nca_n !== n0) begin
      $display("FAIL inv_hold: got %h with %0d pulses, expected f708fb04 and 0", code_a, nca_n - n0); errors++; end
    checks++;
    if (code_b !== 32'hF7080004 || ncb_n - b0 !== 1 || err_b !== 3'd0) begin
      $display("FAIL noinv_frame: got %h, %0d pulses, err %0d, expected f7080004, 1, 0", code_b, ncb_n - b0, err_b); errors++; end
    checks++;
  endtask

  task automatic test_bad_timings;
    int n0;
    tgt = 3'b001; n0 = nca_n;
    hold(1'b0, 700); hold(1'b1, 40);
    if (err_a !== 3'd1 || st_a !== 4'd0) begin
      $display("FAIL bad_sync: got err %0d state %0d, expected 1 and 0", err_a, st_a); errors++; end
    checks++;
    send_sync(SSD); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    hold(1'b0, BBD); hold(1'b1, 110); hold(1'b0, BBD); hold(1'b1, 40);
    if (err_a !== 3'd4 || st_a !== 4'd0) begin
      $display("FAIL bad_space: got err %0d state %0d, expected 4 and 0", err_a, st_a); errors++; end
    checks++;
    send_sync(SSD); send_bit(1'b0, 1'b0);
    hold(1'b0, BBD);
    if (err_a !== 3'd0 || st_a !== 4'd3) begin
      $display("FAIL midframe: got err %0d state %0d, expected 0 and 3", err_a, st_a); errors++; end
    checks++;
    hold(1'b1, 400);
    if (err_a !== 3'd4 || st_a !== 4'd0) begin
      $display("FAIL timeout: got err %0d state %0d, expected 4 and 0", err_a, st_a); errors++; end
    checks++;
    if (nca_n !== n0 || code_a !== 32'hF708FB04) begin
      $display("FAIL bad_nopulse: got %0d pulses code %h, expected 0 and f708fb04", nca_n - n0, code_a); errors++; end
    checks++;
    send_frame(64'hDF20EF10, 32, 1'b0, 1'b0);
    if (code_a !== 32'hDF20EF10 || nca_n - n0 !== 1 || err_a !== 3'd0) begin
      $display("FAIL recover: got %h, %0d pulses, err %0d, expected df20ef10, 1, 0", code_a, nca_n - n0, err_a); errors++; end
    checks++;
  endtask

  task automatic test_repeat_after_reset;
    int r0;
    tgt = 3'b001;
    rst_n_in = 1'b0; repeat (3) @(negedge clk_in); rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    r0 = rpa_n;
    send_sync(RSD); hold(1'b0, BBD); hold(1'b1, 30);
    if (err_a !== 3'd6 || rpa_n !== r0 || code_a !== 32'd0) begin
      $display("FAIL repeat_nocode: got err %0d, %0d pulses, code %h, expected 6, 0, 0", err_a, rpa_n - r0, code_a); errors++; end
    checks++;
  endtask

  task automatic test_glitch;
    int n0;
    tgt = 3'b001; n0 = nca_n;
    send_frame(64'h7F80BF40, 32, 1'b0, 1'b1);
    if (code_a !== 32'h7F80BF40 || nca_n - n0 !== 1 || err_a !== 3'd0) begin
      $display("FAIL glitch: got %h, %0d pulses, err %0d, expected 7f80bf40, 1, 0", code_a, nca_n - n0, err_a); errors++; end
    checks++;
  endtask

  task automatic test_reset_mid_frame;
    int n0;
    logic [31:0] v;
    tgt = 3'b001; n0 = nca_n; v = 32'hF708FB04;
    send_sync(SSD);
    for (int i = 0; i < 16; i++) send_bit(v[i], 1'b0);
    hold(1'b0, 20);
    #2 rst_n_in = 1'b0;
    #1;
    if (code_a !== 32'd0 || st_a !== 4'd0 || err_a !== 3'd0) begin
      $display("FAIL async_reset: got code %h state %0d err %0d, expected 0", code_a, st_a, err_a); errors++; end
    checks++;
    @(negedge clk_in);
    hold(1'b1, 10);
    rst_n_in = 1'b1;
    hold(1'b1, 50);
    if (nca_n !== n0) begin
      $display("FAIL reset_nopulse: got %0d pulses, expected 0", nca_n - n0); errors++; end
    checks++;
    send_frame(64'hF708FB04, 32, 1'b0, 1'b0);
    if (code_a !== 32'hF708FB04 || nca_n - n0 !== 1) begin
      $display("FAIL after_reset: got %h with %0d pulses, expected f708fb04 and 1", code_a, nca_n - n0); errors++; end
    checks++;
  endtask

  task automatic test_param_variant;
    int c0;
    tgt = 3'b100; c0 = ncc_n;
    send_frame(64'hA3C, 12, 1'b1, 1'b0);
    if (code_c !== 12'hA3C) begin
      $display("FAIL msb12_code: got %h, expected a3c", code_c); errors++; end
    checks++;
    if (ncc_n - c0 !== 1 || ncc_cyc - t_mark !== 8 || err_c !== 3'd0) begin
      $display("FAIL msb12_pulse: got %0d pulses latency %0d err %0d, expected 1, 8, 0", ncc_n - c0, ncc_cyc - t_mark, err_c); errors++; end
    checks++;
  endtask

  task automatic test_exclusive;
    if (both_n !== 0 || rp_b !== 1'b0 || rp_c !== 1'b0 || st_b !== 4'd0 || st_c !== 4'd0) begin
      $display("FAIL exclusive: got %0d overlaps, rp_b %b rp_c %b st %0d/%0d, expected all 0", both_n, rp_b, rp_c, st_b, st_c); errors++; end
    checks++;
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_repeat;
    test_inverse;
    test_bad_timings;
    test_repeat_after_reset;
    test_glitch;
    test_reset_mid_frame;
    test_param_variant;
    test_exclusive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
